// File: rtl/line_refill_responder.sv
// ---------------------------------------------------------------------------
// line_refill_responder
//
// Purpose:
//   Read-only burst responder on the slave side of the instruction-cache
//   refill bus. It accepts one read request at a time. It answers with either
//   a whole cache line (LINE_WORDS ascending beats starting at the line base)
//   or a single word, depending on burst_ena at the address handshake. The
//   data comes from an internal word RAM, which a testbench or loader fills
//   through the preload write port.
//
// Optional feature:
//   REFILL_RESP_STALL_EN - when defined, every accepted request waits
//   STALL_CYCLES idle cycles before the first beat. STALL_CYCLES=0 gives the
//   same timing as the undefined build.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   s_araddr    byte address of the request (word index = s_araddr[MEM_AW+1:2])
//   s_arvalid   request valid
//   s_arready   request accepted when s_arvalid && s_arready (IDLE only)
//   burst_ena   1: full-line burst, 0: single word (sampled at handshake)
//   s_rdata     registered read data beat
//   s_rvalid    beat valid
//   s_rlast     final beat of the response
//   s_rready    beat consumed when s_rvalid && s_rready
//   wr_en       preload write strobe (accepted in any state)
//   wr_addr     preload word address
//   wr_data     preload data
// ---------------------------------------------------------------------------
module line_refill_responder #(
    parameter int LINE_WORDS   = 8,
    parameter int MEM_AW       = 12,
    parameter int STALL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic              burst_ena,
    output logic [31:0]       s_rdata,
    output logic              s_rvalid,
    output logic              s_rlast,
    input  logic              s_rready,
    input  logic              wr_en,
    input  logic [MEM_AW-1:0] wr_addr,
    input  logic [31:0]       wr_data
);

    localparam int OFFW  = $clog2(LINE_WORDS);
    localparam int CW    = OFFW + 1;
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [CW-1:0] LAST_CNT = CW'(LINE_WORDS - 1);

`ifdef REFILL_RESP_STALL_EN
    localparam bit         USE_STALL  = (STALL_CYCLES != 0);
    localparam logic [3:0] STALL_LAST = 4'(STALL_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1
`ifdef REFILL_RESP_STALL_EN
        , ST_WAIT = 2'd2
`endif
    } state_t;

    state_t state_q, state_n;

    logic [MEM_AW-1:0] cur_idx_q, cur_idx_n;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_n;
    logic              rvalid_q, rvalid_n;
    logic              rlast_q, rlast_n;
    logic [31:0]       rdata_q;

    logic              fetch_en;
    logic [MEM_AW-1:0] fetch_idx;

`ifdef REFILL_RESP_STALL_EN
    logic              burst_q, burst_n;
    logic [3:0]        stall_cnt_q, stall_cnt_n;
`else
    logic              unused_stall;
    assign unused_stall = (STALL_CYCLES != 0);
`endif

    logic [31:0] mem [0:DEPTH-1];

    logic              ar_hs;
    logic [MEM_AW-1:0] ar_idx;
    logic [MEM_AW-1:0] ar_base;
    logic              unused_addr;

    assign ar_idx  = s_araddr[MEM_AW+1:2];
    assign ar_base = {ar_idx[MEM_AW-1:OFFW], {OFFW{1'b0}}};
    // Bits above the RAM depth wrap the index, and byte-lane bits are ignored.
    assign unused_addr = ^{s_araddr[31:MEM_AW+2], s_araddr[1:0]};

    // Request acceptance is only possible from IDLE and never during reset.
    assign s_arready = (state_q == ST_IDLE) && !rst;
    assign ar_hs     = s_arvalid && s_arready;

    assign s_rvalid = rvalid_q;
    assign s_rlast  = rlast_q;
    assign s_rdata  = rdata_q;

    // State and control registers. Reset aborts any response in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_idx_q   <= '0;
            beat_cnt_q  <= '0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
`ifdef REFILL_RESP_STALL_EN
            burst_q     <= 1'b0;
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_n;
            cur_idx_q   <= cur_idx_n;
            beat_cnt_q  <= beat_cnt_n;
            rvalid_q    <= rvalid_n;
            rlast_q     <= rlast_n;
`ifdef REFILL_RESP_STALL_EN
            burst_q     <= burst_n;
            stall_cnt_q <= stall_cnt_n;
`endif
        end
    end

    // Next-state logic. A RAM fetch is issued on the edge that puts a new
    // beat on the bus: the handshake edge (or end of the stall), and every
    // non-final beat handshake. This keeps the beats back to back, and
    // s_rdata only changes when a beat is consumed.
    always_comb begin
        state_n    = state_q;
        cur_idx_n  = cur_idx_q;
        beat_cnt_n = beat_cnt_q;
        rvalid_n   = rvalid_q;
        rlast_n    = rlast_q;
        fetch_en   = 1'b0;
        fetch_idx  = cur_idx_q;
`ifdef REFILL_RESP_STALL_EN
        burst_n     = burst_q;
        stall_cnt_n = stall_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    cur_idx_n  = burst_ena ? ar_base : ar_idx;
                    beat_cnt_n = '0;
`ifdef REFILL_RESP_STALL_EN
                    burst_n = burst_ena;
                    if (USE_STALL) begin
                        state_n     = ST_WAIT;
                        stall_cnt_n = '0;
                    end else begin
                        state_n   = ST_BEAT;
                        fetch_en  = 1'b1;
                        fetch_idx = cur_idx_n;
                        rvalid_n  = 1'b1;
                        rlast_n   = !burst_ena;
                    end
`else
                    state_n   = ST_BEAT;
                    fetch_en  = 1'b1;
                    fetch_idx = cur_idx_n;
                    rvalid_n  = 1'b1;
                    rlast_n   = !burst_ena;
`endif
                end
            end

`ifdef REFILL_RESP_STALL_EN
            ST_WAIT: begin
                if (stall_cnt_q == STALL_LAST) begin
                    state_n   = ST_BEAT;
                    fetch_en  = 1'b1;
                    fetch_idx = cur_idx_q;
                    rvalid_n  = 1'b1;
                    rlast_n   = !burst_q;
                end else begin
                    stall_cnt_n = stall_cnt_q + 4'd1;
                end
            end
`endif

            ST_BEAT: begin
                if (rvalid_q && s_rready) begin
                    if (rlast_q) begin
                        state_n  = ST_IDLE;
                        rvalid_n = 1'b0;
                        rlast_n  = 1'b0;
                    end else begin
                        // Only the in-line offset advances, so the burst
                        // never walks past the end of its cache line.
                        beat_cnt_n = beat_cnt_q + CW'(1);
                        cur_idx_n  = {cur_idx_q[MEM_AW-1:OFFW], beat_cnt_n[OFFW-1:0]};
                        fetch_en   = 1'b1;
                        fetch_idx  = cur_idx_n;
                        rlast_n    = (beat_cnt_n == LAST_CNT);
                    end
                end
            end

            default: begin
                state_n  = ST_IDLE;
                rvalid_n = 1'b0;
                rlast_n  = 1'b0;
            end
        endcase
    end

    // Registered read port. A preload write on the same edge as the fetch
    // of the same word lands after the read, so the beat carries the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (fetch_en) begin
            rdata_q <= mem[fetch_idx];
        end
    end

    // Preload write port. It is never reset, so the RAM keeps its contents
    // across resets.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule
